// File: rtl/wb_data_ram_if.sv
// Wishbone B4 classic-cycle bus between the data-memory master and the RAM slave.
// A request is cyc & stb (with we/adr/dat/sel stable alongside it); the slave ends it with a one-cycle ack or err pulse.
interface wb_data_ram_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_data_ram.sv
// Wishbone classic slave data RAM with programmable wait states, byte-lane writes
// and error termination for addresses beyond the implemented depth.
module wb_data_ram #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic         clk,
  input  logic         rst,
  wb_data_ram_if.slave wb,
  output logic [1:0]   state_dbg
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    latch;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic                    we_q;
  logic [31:0]             dat_q;
  logic [3:0]              sel_q;
  logic                    oor_q;
  logic [31:0]             dat_o_q;

  logic [3:0][7:0]         mem [DEPTH];

  logic                    req;
  logic                    oor_in;
  logic [ADDR_WIDTH-1:0]   idx_in;
  logic                    unused_adr;

  assign req        = wb.wb_cyc_i & wb.wb_stb_i;
  assign oor_in     = |wb.wb_adr_i[31:ADDR_WIDTH+2];
  assign idx_in     = wb.wb_adr_i[ADDR_WIDTH+1:2];
  assign unused_adr = ^wb.wb_adr_i[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          latch   = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        // Losing cyc here abandons the transfer silently; no termination, no write.
        if (!wb.wb_cyc_i) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states RESP is entered straight from IDLE, so the read
  // must use the live request rather than the not-yet-latched copy.
  logic                  rd_we;
  logic                  rd_oor;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  load_rd;

  assign rd_we   = latch ? wb.wb_we_i : we_q;
  assign rd_oor  = latch ? oor_in     : oor_q;
  assign rd_idx  = latch ? idx_in     : idx_q;
  assign load_rd = (state_d == S_RESP) && !rd_we;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      dat_q   <= 32'd0;
      sel_q   <= 4'd0;
      oor_q   <= 1'b0;
      dat_o_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        idx_q <= idx_in;
        we_q  <= wb.wb_we_i;
        dat_q <= wb.wb_dat_i;
        sel_q <= wb.wb_sel_i;
        oor_q <= oor_in;
      end
      if (load_rd) begin
        dat_o_q <= rd_oor ? 32'd0 : mem[rd_idx];
      end
    end
  end

  // Storage is never cleared; the commit happens on the edge closing RESP.
  always_ff @(posedge clk) begin
    if (rst && (state_q == S_RESP) && we_q && !oor_q) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_q[i]) mem[idx_q][i] <= dat_q[8*i +: 8];
      end
    end
  end

  assign wb.wb_ack_o = (state_q == S_RESP) & ~oor_q;
  assign wb.wb_err_o = (state_q == S_RESP) &  oor_q;
  assign wb.wb_dat_o = dat_o_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_wb_data_ram.sv
// Bench for wb_data_ram: three instances (0, 1 and 3 wait states) driven by
// scenario tasks and a randomized run checked against a word-array memory model.
`timescale 1ns/1ps
module tb_wb_data_ram;

  localparam int NDUT = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NDUT-1:0]   cyc, stb, we, ack, err;
  logic [31:0]       adr   [NDUT];
  logic [31:0]       dat_w [NDUT];
  logic [31:0]       rdat  [NDUT];
  logic [3:0]        sel   [NDUT];
  logic [1:0]        dbg   [NDUT];

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [NDUT][1024];
  logic [31:0] exp_q[$];

  int          lat;
  bit          t_ack, t_err;
  logic [31:0] rd;
  logic [1:0]  tail;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    wb_data_ram_if bus ();
    assign bus.wb_cyc_i = cyc[g];
    assign bus.wb_stb_i = stb[g];
    assign bus.wb_we_i  = we[g];
    assign bus.wb_adr_i = adr[g];
    assign bus.wb_dat_i = dat_w[g];
    assign bus.wb_sel_i = sel[g];
    assign ack[g]       = bus.wb_ack_o;
    assign err[g]       = bus.wb_err_o;
    assign rdat[g]      = bus.wb_dat_o;

    wb_data_ram #(
      .ADDR_WIDTH  (10),
      .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .wb        (bus.slave),
      .state_dbg (dbg[g])
    );
  end

  function automatic int ws(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // One complete request: hold until termination (bounded), release, then sample the following cycle.
  task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, output int l, output bit k, output bit e,
                      output logic [31:0] r, output logic [1:0] tl);
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dat_w[d] = wd; sel[d] = s;
    l = -1; k = 1'b0; e = 1'b0; r = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ack[d] || err[d]) begin
        l = n; k = ack[d]; e = err[d]; r = rdat[d];
        break;
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
    @(negedge clk);
    tl = {ack[d], err[d]};
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; adr[d] = '0; dat_w[d] = '0; sel[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      checks++; if (ack[d] !== 1'b0) begin errors++; $display("FAIL reset_ack dut%0d got %b want 0", d, ack[d]); end
      checks++; if (err[d] !== 1'b0) begin errors++; $display("FAIL reset_err dut%0d got %b want 0", d, err[d]); end
      checks++; if (rdat[d] !== 32'd0) begin errors++; $display("FAIL reset_dat dut%0d got %h want 0", d, rdat[d]); end
      checks++; if (dbg[d] !== 2'd0) begin errors++; $display("FAIL reset_state dut%0d got %0d want 0", d, dbg[d]); end
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_rw();
    xfer(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, t_ack, t_err, rd, tail);
    mdl[1][4] = 32'hDEADBEEF;
    checks++; if (lat !== 2) begin errors++; $display("FAIL word_wr_lat got %0d want 2", lat); end
    checks++; if (t_ack !== 1'b1 || t_err !== 1'b0) begin errors++; $display("FAIL word_wr_term got ack=%b err=%b want ack=1 err=0", t_ack, t_err); end
    checks++; if (tail !== 2'b00) begin errors++; $display("FAIL word_wr_width got %b want 00", tail); end
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, lat, t_ack, t_err, rd, tail);
    checks++; if (lat !== 2) begin errors++; $display("FAIL word_rd_lat got %0d want 2", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_rd_data got %h want deadbeef", rd); end
  endtask

  task automatic test_byte_lanes();
    xfer(1, 1'b1, 32'h10, 32'h11223344, 4'b1001, lat, t_ack, t_err, rd, tail);
    mdl[1][4] = merge(mdl[1][4], 32'h11223344, 4'b1001);
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, lat, t_ack, t_err, rd, tail);
    checks++; if (rd !== 32'h11ADBE44) begin errors++; $display("FAIL lane_rd got %h want 11adbe44", rd); end
    xfer(1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, lat, t_ack, t_err, rd, tail);
    checks++; if (t_ack !== 1'b1 || t_err !== 1'b0) begin errors++; $display("FAIL lane_sel0_term got ack=%b err=%b want ack=1 err=0", t_ack, t_err); end
    xfer(1, 1'b0, 32'h13, 32'h0, 4'h0, lat, t_ack, t_err, rd, tail);
    checks++; if (rd !== 32'h11ADBE44) begin errors++; $display("FAIL lane_sel0_rd got %h want 11adbe44", rd); end
  endtask

  task automatic test_wait_sweep();
    logic [31:0] wd;
    for (int d = 0; d < NDUT; d++) begin
      wd = $urandom;
      xfer(d, 1'b1, 32'h40, wd, 4'hF, lat, t_ack, t_err, rd, tail);
      mdl[d][16] = wd;
      checks++; if (lat !== ws(d) + 1) begin errors++; $display("FAIL sweep_wr_lat dut%0d got %0d want %0d", d, lat, ws(d) + 1); end
      checks++; if (tail !== 2'b00) begin errors++; $display("FAIL sweep_width dut%0d got %b want 00", d, tail); end
      xfer(d, 1'b0, 32'h40, 32'h0, 4'hF, lat, t_ack, t_err, rd, tail);
      checks++; if (lat !== ws(d) + 1) begin errors++; $display("FAIL sweep_rd_lat dut%0d got %0d want %0d", d, lat, ws(d) + 1); end
      checks++; if (rd !== wd) begin errors++; $display("FAIL sweep_rd_data dut%0d got %h want %h", d, rd, wd); end
    end
  endtask

  // Write then read of the same word with cyc/stb held high across the turnaround.
  task automatic test_back_to_back();
    logic [31:0] wd;
    int n1, n2;
    for (int d = 0; d < NDUT; d++) begin
      wd = $urandom;
      n1 = -1; n2 = -1;
      @(negedge clk);
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b1; adr[d] = 32'h50; dat_w[d] = wd; sel[d] = 4'hF;
      for (int n = 1; n <= 40; n++) begin
        @(negedge clk);
        if (ack[d] || err[d]) begin n1 = n; break; end
      end
      we[d] = 1'b0;
      for (int n = 1; n <= 40; n++) begin
        @(negedge clk);
        if (ack[d] || err[d]) begin n2 = n; rd = rdat[d]; break; end
      end
      cyc[d] = 1'b0; stb[d] = 1'b0;
      mdl[d][20] = wd;
      checks++; if (n1 !== ws(d) + 1) begin errors++; $display("FAIL b2b_first dut%0d got %0d want %0d", d, n1, ws(d) + 1); end
      checks++; if (n2 !== ws(d) + 2) begin errors++; $display("FAIL b2b_period dut%0d got %0d want %0d", d, n2, ws(d) + 2); end
      checks++; if (rd !== wd) begin errors++; $display("FAIL b2b_raw dut%0d got %h want %h", d, rd, wd); end
      @(negedge clk);
      checks++; if (ack[d] !== 1'b0) begin errors++; $display("FAIL b2b_width dut%0d got %b want 0", d, ack[d]); end
    end
  endtask

  task automatic test_out_of_range();
    xfer(1, 1'b1, 32'h0, 32'hA5A55A5A, 4'hF, lat, t_ack, t_err, rd, tail);
    mdl[1][0] = 32'hA5A55A5A;
    xfer(1, 1'b1, 32'h00001000, 32'h0BADF00D, 4'hF, lat, t_ack, t_err, rd, tail);
    checks++; if (t_err !== 1'b1 || t_ack !== 1'b0) begin errors++; $display("FAIL oor_wr_term got ack=%b err=%b want ack=0 err=1", t_ack, t_err); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL oor_wr_lat got %0d want 2", lat); end
    checks++; if (tail !== 2'b00) begin errors++; $display("FAIL oor_width got %b want 00", tail); end
    xfer(1, 1'b0, 32'h0, 32'h0, 4'hF, lat, t_ack, t_err, rd, tail);
    checks++; if (rd !== 32'hA5A55A5A) begin errors++; $display("FAIL oor_keep got %h want a5a55a5a", rd); end
    xfer(1, 1'b0, 32'h00001004, 32'h0, 4'hF, lat, t_ack, t_err, rd, tail);
    checks++; if (t_err !== 1'b1 || t_ack !== 1'b0) begin errors++; $display("FAIL oor_rd_term got ack=%b err=%b want ack=0 err=1", t_ack, t_err); end
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL oor_rd_data got %h want 0", rd); end
  endtask

  task automatic test_abort();
    bit seen;
    xfer(2, 1'b1, 32'h20, 32'h12345678, 4'hF, lat, t_ack, t_err, rd, tail);
    mdl[2][8] = 32'h12345678;
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h20; dat_w[2] = 32'hCAFEF00D; sel[2] = 4'hF;
    @(negedge clk);
    @(negedge clk);
    cyc[2] = 1'b0; stb[2] = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ack[2] || err[2]) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_term got 1 want 0"); end
    checks++; if (dbg[2] !== 2'd0) begin errors++; $display("FAIL abort_state got %0d want 0", dbg[2]); end
    xfer(2, 1'b0, 32'h20, 32'h0, 4'hF, lat, t_ack, t_err, rd, tail);
    checks++; if (rd !== mdl[2][8]) begin errors++; $display("FAIL abort_rd got %h want %h", rd, mdl[2][8]); end
  endtask

  task automatic test_reset_mid();
    xfer(2, 1'b1, 32'h30, 32'h0F1E2D3C, 4'hF, lat, t_ack, t_err, rd, tail);
    mdl[2][12] = 32'h0F1E2D3C;
    xfer(2, 1'b0, 32'h20, 32'h0, 4'hF, lat, t_ack, t_err, rd, tail);
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h30; dat_w[2] = 32'hFFFF0000; sel[2] = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ack[2] !== 1'b0 || err[2] !== 1'b0) begin errors++; $display("FAIL rstmid_term got ack=%b err=%b want 0 0", ack[2], err[2]); end
    checks++; if (rdat[2] !== 32'd0) begin errors++; $display("FAIL rstmid_dat got %h want 0", rdat[2]); end
    checks++; if (dbg[2] !== 2'd0) begin errors++; $display("FAIL rstmid_state got %0d want 0", dbg[2]); end
    cyc[2] = 1'b0; stb[2] = 1'b0;
    rst = 1'b1;
    xfer(2, 1'b0, 32'h30, 32'h0, 4'hF, lat, t_ack, t_err, rd, tail);
    checks++; if (t_ack !== 1'b1 || lat !== 4) begin errors++; $display("FAIL rstmid_next got ack=%b lat=%0d want ack=1 lat=4", t_ack, lat); end
    checks++; if (rd !== 32'h0F1E2D3C) begin errors++; $display("FAIL rstmid_mem got %h want 0f1e2d3c", rd); end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, e;
    logic [3:0]  s;
    bit          w, oor;
    int          widx;
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 64; i < 80; i++) begin
        wd = $urandom;
        xfer(d, 1'b1, 32'(i * 4), wd, 4'hF, lat, t_ack, t_err, rd, tail);
        mdl[d][i] = wd;
      end
      for (int k = 0; k < 30; k++) begin
        oor  = ($urandom_range(0, 5) == 0);
        w    = $urandom_range(0, 1) == 1;
        s    = 4'($urandom_range(0, 15));
        wd   = $urandom;
        widx = $urandom_range(64, 79);
        if (oor) a = (32'h1000 << $urandom_range(0, 19)) | ($urandom & 32'hFFF);
        else     a = 32'(widx * 4) | 32'($urandom_range(0, 3));
        if (!w) exp_q.push_back(oor ? 32'd0 : mdl[d][widx]);
        xfer(d, w, a, wd, s, lat, t_ack, t_err, rd, tail);
        checks++; if (t_ack !== !oor || t_err !== oor) begin errors++; $display("FAIL rand_term dut%0d adr=%h got ack=%b err=%b want err=%b", d, a, t_ack, t_err, oor); end
        checks++; if (lat !== ws(d) + 1) begin errors++; $display("FAIL rand_lat dut%0d got %0d want %0d", d, lat, ws(d) + 1); end
        if (!w) begin
          e = exp_q.pop_front();
          checks++; if (rd !== e) begin errors++; $display("FAIL rand_rd dut%0d adr=%h got %h want %h", d, a, rd, e); end
        end else if (!oor) begin
          mdl[d][widx] = merge(mdl[d][widx], wd, s);
        end
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_wait_sweep();
    test_back_to_back();
    test_out_of_range();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
